// File: rtl/sipo_deserializer.sv
// MSB-first serial-to-parallel receiver with a registered valid/ready word output.
// Define PARITY_EN to expect one even-parity bit after each word's LSB.
module sipo_deserializer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             serial_in,
    input  logic             frame_start,
    input  logic             out_ready,
    output logic [WIDTH-1:0] parallel_out,
    output logic             out_valid,
    output logic             busy,
    output logic             overrun,
    output logic             parity_err
);

`ifdef PARITY_EN
    localparam int FRAME_BITS = WIDTH + 1;
`else
    localparam int FRAME_BITS = WIDTH;
`endif
    localparam int CNT_W   = $clog2(WIDTH + 2);
    localparam int SHIFT_W = FRAME_BITS - 1;

    typedef enum logic {IDLE, SHIFT} state_t;

    state_t             state;
    logic [CNT_W-1:0]   count;
    logic [SHIFT_W-1:0] shift;
    logic [SHIFT_W:0]   frame_bits;
    logic               done;
    logic [WIDTH-1:0]   word;
    logic               word_perr;

`ifdef PARITY_EN
    function automatic logic parity_odd(input logic [SHIFT_W:0] v);
        return ^v;
    endfunction
`endif

    // The shift register only holds the bits before the final one; the final
    // bit is taken straight from serial_in so the word is ready on that edge.
    assign frame_bits = {shift, serial_in};
    assign done       = (state == SHIFT) && (count == CNT_W'(FRAME_BITS - 1));

`ifdef PARITY_EN
    assign word      = frame_bits[SHIFT_W:1];
    assign word_perr = parity_odd(frame_bits);
`else
    assign word      = frame_bits;
    assign word_perr = 1'b0;
`endif

    assign busy = (state == SHIFT);

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            count        <= '0;
            shift        <= '0;
            parallel_out <= '0;
            out_valid    <= 1'b0;
            overrun      <= 1'b0;
            parity_err   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        shift <= SHIFT_W'(serial_in);
                        count <= CNT_W'(1);
                        state <= SHIFT;
                    end
                end
                SHIFT: begin
                    // A new frame_start always wins: it aborts a partial word
                    // or chains onto a word completing this cycle.
                    if (frame_start) begin
                        shift <= SHIFT_W'(serial_in);
                        count <= CNT_W'(1);
                    end else if (done) begin
                        shift <= frame_bits[SHIFT_W-1:0];
                        count <= '0;
                        state <= IDLE;
                    end else begin
                        shift <= frame_bits[SHIFT_W-1:0];
                        count <= count + CNT_W'(1);
                    end
                end
            endcase

            if (done) begin
                if (!out_valid || out_ready) begin
                    parallel_out <= word;
                    parity_err   <= word_perr;
                    out_valid    <= 1'b1;
                end else begin
                    overrun <= 1'b1;
                end
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule
